// File: rtl/dmac_engine.sv
// dmac_engine: word-granular AXI4-style DMA copy engine staging read bursts in a 16-word buffer.
// Define DMAC_ENGINE_SINGLE_BEAT_EN to force single-beat bursts with a one-word buffer.
module dmac_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] dst_addr_i,
    input  logic [15:0] byte_len_i,
    input  logic        start_i,
    output logic        done_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);
    typedef enum logic [2:0] {IDLE, RREQ, RDATA, WREQ, WDATA, WRESP} state_t;
    state_t      state, state_nx;
    logic [29:0] src, dst;
    logic [13:0] rem;
    logic [4:0]  idx, beats;
    logic [3:0]  blen;
    logic        last;
    logic        unused;

    assign unused = ^{src_addr_i[1:0], dst_addr_i[1:0], byte_len_i[1:0], rresp_i, rlast_i, bresp_i};

`ifdef DMAC_ENGINE_SINGLE_BEAT_EN
    logic [31:0] mem;
    assign beats   = {4'd0, rem != 14'd0};
    assign wdata_o = mem;
    // Capture the single staged word on each accepted read beat.
    always_ff @(posedge clk) begin
        if (state == RDATA && rvalid_i) mem <= rdata_i;
    end
`else
    logic [31:0] mem [16];
    logic [10:0] src_room, dst_room;
    logic [4:0]  cap_rem, cap_src;
    assign src_room = 11'd1024 - {1'b0, src[9:0]};
    assign dst_room = 11'd1024 - {1'b0, dst[9:0]};
    assign cap_rem  = (rem > 14'd16) ? 5'd16 : rem[4:0];
    assign cap_src  = ({6'd0, cap_rem} > src_room) ? src_room[4:0] : cap_rem;
    assign beats    = ({6'd0, cap_src} > dst_room) ? dst_room[4:0] : cap_src;
    assign wdata_o  = mem[idx[3:0]];
    // Stage read beats in order so the write burst can replay them.
    always_ff @(posedge clk) begin
        if (state == RDATA && rvalid_i) mem[idx[3:0]] <= rdata_i;
    end
`endif

    assign last      = (idx + 5'd1) == beats;
    assign blen      = beats[3:0] - 4'd1;
    assign done_o    = state == IDLE;
    assign arvalid_o = state == RREQ;
    assign rready_o  = state == RDATA;
    assign awvalid_o = state == WREQ;
    assign wvalid_o  = state == WDATA;
    assign bready_o  = state == WRESP;
    assign araddr_o  = {src, 2'b00};
    assign awaddr_o  = {dst, 2'b00};
    assign arlen_o   = arvalid_o ? blen : 4'd0;
    assign awlen_o   = awvalid_o ? blen : 4'd0;
    assign wlast_o   = wvalid_o && last;
    assign arsize_o  = 3'b010;
    assign awsize_o  = 3'b010;
    assign arburst_o = 2'b01;
    assign awburst_o = 2'b01;
    assign wstrb_o   = 4'hF;

    // State register; reset abandons any outstanding bus transaction.
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    // Next-state sequencing: read burst, write burst, response, repeat until no words remain.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i && byte_len_i[15:2] != 14'd0) state_nx = RREQ;
            RREQ:    if (arready_i) state_nx = RDATA;
            RDATA:   if (rvalid_i && last) state_nx = WREQ;
            WREQ:    if (awready_i) state_nx = WDATA;
            WDATA:   if (wready_i && last) state_nx = WRESP;
            WRESP:   if (bvalid_i) state_nx = (rem == {9'd0, beats}) ? IDLE : RREQ;
            default: state_nx = IDLE;
        endcase
    end

    // Transfer bookkeeping: word addresses, words remaining and beat index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src <= '0;
            dst <= '0;
            rem <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src <= src_addr_i[31:2];
                        dst <= dst_addr_i[31:2];
                        rem <= byte_len_i[15:2];
                        idx <= '0;
                    end
                end
                RDATA: if (rvalid_i) idx <= last ? 5'd0 : idx + 5'd1;
                WDATA: if (wready_i) idx <= last ? 5'd0 : idx + 5'd1;
                WRESP: begin
                    if (bvalid_i) begin
                        src <= src + {25'd0, beats};
                        dst <= dst + {25'd0, beats};
                        rem <= rem - {9'd0, beats};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/dmac_engine.md
# dmac_engine

DMA transfer engine that consumes the configuration block's outputs (source address, destination address, byte length, start pulse) and returns its `done` status. Copies `byte_len` bytes from source to destination over an AXI4-style master using read bursts staged in a 16-word internal buffer, then write bursts. It is idle when `done_o` is 1.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- src_addr_i  in  32  source byte address; sampled on start
- dst_addr_i  in  32  destination byte address; sampled on start
- byte_len_i  in  16  transfer length in bytes; sampled on start
- start_i  in  1  one-cycle start pulse
- done_o  out  1  1 when idle (no transfer in flight)
- araddr_o, arlen_o[3:0], arvalid_o  out  read address channel
- arready_i  in  1  read address ready
- arsize_o[2:0], arburst_o[1:0]  out  constant 3'b010 (4 B) and 2'b01 (INCR)
- rdata_i[31:0], rresp_i[1:0], rlast_i, rvalid_i  in  read data channel
- rready_o  out  1  read data ready
- awaddr_o, awlen_o[3:0], awvalid_o  out  write address channel
- awready_i  in  1  write address ready
- awsize_o[2:0], awburst_o[1:0]  out  constant 3'b010 and 2'b01
- wdata_o[31:0], wstrb_o[3:0], wlast_o, wvalid_o  out  write data channel; wstrb_o constant 4'hF
- wready_i  in  1  write data ready
- bresp_i[1:0], bvalid_i  in  write response channel
- bready_o  out  1  write response ready

## Operation
- Word-granular transfers. Address bits [1:0] are forced to 0 on the bus. Word count is byte_len_i[15:2] (14 bits). Bits [1:0] of the length are dropped.
- FSM states: IDLE, RREQ, RDATA, WREQ, WDATA, WRESP.
- IDLE: done_o=1. When start_i=1, latch the addresses and the word count. If the word count is 0, stay in IDLE. Otherwise go to RREQ.
- Burst length per iteration: beats = min(remaining words, 16, src words to next 4 KB boundary, dst words to next 4 KB boundary). Words to boundary = (4096 − addr[11:0])>>2. arlen/awlen = beats−1.
- RREQ: arvalid_o=1 until arready_i, then go to RDATA.
- RDATA: rready_o=1. Each rvalid_i beat is stored in buf[idx] and idx increments. Leave after `beats` beats; the beat count governs, not rlast_i.
- WREQ: awvalid_o=1 until awready_i, then go to WDATA.
- WDATA: wvalid_o=1 and wdata_o=buf[idx]. idx advances on wready_i. wlast_o=1 on the final beat. After the last beat accepted, go to WRESP.
- WRESP: bready_o=1. On bvalid_i: src += 4·beats, dst += 4·beats, remaining −= beats. If remaining=0 go to IDLE, else go to RREQ.
- rresp_i and bresp_i are ignored; the transfer always completes.
- start_i outside IDLE is ignored.
- Every valid signal, once asserted, stays high with stable payload until its ready is seen.

## Timing
- Reset values: all valids/readies 0, done_o=1, addresses/lens 0, wlast_o=0, buffer contents don't-care.
- Start handshake: start_i high at edge N gives done_o=0 and arvalid_o=1 from cycle N+1.
- Latency with all readies tied high and rvalid back-to-back, for a single burst of B beats:
  - RREQ: 1 cycle
  - RDATA: B cycles
  - WREQ: 1 cycle
  - WDATA: B cycles
  - WRESP: until bvalid
  - done_o rises the cycle after the final bvalid handshake.
- Reset mid-transfer returns to IDLE with all valids low the next cycle. Outstanding bus transactions are abandoned.

## Configuration
- DMAC_ENGINE_SINGLE_BEAT_EN defined: beats is forced to 1 (arlen/awlen=0, wlast_o=1 every beat); the buffer reduces to one word.
- Undefined: bursts of up to 16 beats as described above.

## Test plan
- 64 B transfer, src 0x1000, dst 0x2000, readies high: one AR with len 15, one AW with len 15, dst memory equals src, done_o returns to 1.
- src 0x0FF8, dst 0x3000, 32 B: bursts are AR 0x0FF8 len 1, then AR 0x1000 len 5; AW 0x3000 len 1, then 0x3008 len 5; data correct.
- Random backpressure on arready/awready/wready/rvalid/bvalid: payload is stable while valid is high; final memory is correct.
- byte_len 0: done_o stays 1 and no bus activity. byte_len 6: exactly one beat transferred.
- start_i pulsed while busy with a different src: ignored; the original transfer completes unchanged.
- rst_n low mid-WDATA: the next cycle all valids are 0 and done_o=1; a new start then runs a correct transfer.
